y_fetch_queue: RTL and testbench
================================

Name: y_fetch_queue

Overview:
- Instruction fetch front end with a small prefetch buffer. It owns the fetch PC and issues word requests to instruction memory over a req/ack handshake with variable latency.
- It delivers {ins, pc, pc+4} to the decode stage through a valid/ready handshake.
- It sits directly upstream of decode (yID) and replaces the single-cycle yIF/PC-increment path.
- Branch, jump and interrupt redirects from the PC-select logic flush the buffer and restart fetch.

Parameters:
- DEPTH, 2, prefetch buffer entries (power of two, at least 2).
- RESET_PC, 32'h80, fetch address after reset (interrupt/boot entry point).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- redirect  in  1  flush and restart fetch at redirect_pc (branch, jump or INT).
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored (forced to 0).
- imem_req  out  1  memory request.
- imem_addr  out  32  word-aligned request address.
- imem_ack  in  1  one-cycle acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction.
- id_valid  out  1  buffer head is valid.
- id_ins  out  32  head instruction.
- id_pc  out  32  head instruction address.
- id_pcp4  out  32  id_pc + 4.
- id_ready  in  1  decode accepts the head this cycle.

Behaviour:
- Reset, synchronous, active-high: fetch_pc=RESET_PC, buffer empty (count=0), state=IDLE, imem_req=0, id_valid=0. id_ins, id_pc and id_pcp4 reset to 0.
- Reset applied mid-transaction abandons any outstanding request. A late imem_ack arriving after reset is ignored. rst has priority over every other input.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - DISCARD: request outstanding whose data must be dropped.
- IDLE -> WAIT when count < DEPTH and redirect=0. Next cycle: imem_req=1, imem_addr=fetch_pc.
- In WAIT, imem_req and imem_addr stay stable until imem_ack.
- Only one request is outstanding at any time. A request is issued only if a free slot exists, so the buffer never overflows.
- WAIT with imem_ack and no redirect:
  - push {imem_rdata, fetch_pc}; fetch_pc += 4 (wraps mod 2^32).
  - If the post-push/pop count < DEPTH, re-issue immediately (back-to-back, imem_req stays 1 with the new address next cycle). Otherwise go to IDLE.
- Pop occurs when id_valid & id_ready: the head advances one entry. Push and pop in the same cycle leave count unchanged.
- id_valid = (count != 0). Outputs come straight from the buffer head, so the minimum latency from ack to id_valid is 1 cycle.
- Redirect, all cases:
  - buffer flushed (count=0, id_valid=0 next cycle);
  - fetch_pc = {redirect_pc[31:2],2'b00};
  - any same-cycle pop or push is cancelled.
- Redirect per state:
  - In IDLE: go to IDLE and issue to the new PC next cycle.
  - In WAIT without ack: go to DISCARD; imem_req is held until ack.
  - In WAIT with same-cycle ack: data dropped, go to IDLE, issue to the new PC next cycle.
- DISCARD:
  - on ack, data dropped and go to IDLE;
  - a further redirect updates fetch_pc and stays in DISCARD.
- id_pcp4 = id_pc + 4, computed combinationally from the stored PC.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, two 32-bit outputs are added:
  - perf_stall: increments each cycle with id_valid=0 and state != DISCARD;
  - perf_discard: increments on each dropped ack, from DISCARD or a same-cycle redirect.
- Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- When undefined, the ports and logic are absent and all other behaviour is identical.

Decomposition:
- Package y_cpu_pkg holds:
  - XLEN=32;
  - INS_BYTES=4;
  - fetch FSM enum {IDLE, WAIT, DISCARD};
  - buffer entry struct {ins[31:0], pc[31:0]}.
- Sub-module y_fetch_fifo: DEPTH-entry synchronous FIFO with push, pop, flush, count and head outputs.
- FSM, fetch PC, redirect and optional counters live in the top module.

Test Plan:
- Reset then ack 1 cycle after each req, id_ready=1: requests to 0x80, 0x84, 0x88 in order. id_pc/id_pcp4 = 0x80/0x84, then 0x84/0x88; id_ins equals the supplied data.
- id_ready=0, zero-latency memory: exactly 2 fetches (0x80, 0x84) complete, then imem_req=0. Raise id_ready: fetch resumes at 0x88 and the head pops in order.
- Redirect to 0x200 while WAIT for 0x84 with ack 3 cycles late: ack data dropped and not delivered. Next request is addr 0x200, and the first id_pc after it is 0x200.
- Redirect to 0x300 in the same cycle as an ack and a pop: count=0 and id_valid=0 next cycle, next imem_addr=0x300, popped entry not re-delivered.
- fetch_pc=32'hFFFF_FFFC with an ack: next imem_addr=0x0. Also check redirect_pc=0x203 is fetched as 0x200.
- With IF_PERF_CNT_EN: 5 empty cycles plus 1 discarded ack -> perf_stall=5, perf_discard=1. rst clears both to 0.

Source files
------------

// File: rtl/y_cpu_pkg.sv
// y_cpu_pkg: shared widths, fetch FSM states and prefetch buffer entry type.
package y_cpu_pkg;
    localparam int XLEN      = 32;
    localparam int INS_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] ins;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/y_fetch_fifo.sv
// y_fetch_fifo: DEPTH-entry synchronous prefetch FIFO.
// Ports: clk, rst (sync, active-high); push/din write an entry, pop advances
// the head, flush empties the buffer (wins over push/pop); head is the oldest
// entry, count the current occupancy (0..DEPTH).
import y_cpu_pkg::*;

module y_fetch_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           din,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          do_pop;

    assign do_pop = pop && count != '0;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/y_fetch_queue.sv
// y_fetch_queue: instruction fetch front end with a prefetch buffer.
// Ports: clk, rst (sync, active-high); redirect/redirect_pc restart fetch;
// imem_req/imem_addr/imem_ack/imem_rdata is the memory handshake (one request
// outstanding); id_valid/id_ins/id_pc/id_pcp4/id_ready deliver to decode.
// Optional macro IF_PERF_CNT_EN adds saturating perf_stall/perf_discard outputs.
import y_cpu_pkg::*;

module y_fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_ins,
    output logic [31:0] id_pc,
    output logic [31:0] id_pcp4,
    input  logic        id_ready
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_discard
`endif
);
    localparam int              CW   = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] STEP = XLEN'(INS_BYTES);

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc, next_pc, redir_pc;
    logic [CW-1:0]   count, post_count;
    fetch_entry_t    head, din;
    logic            push, pop;

    assign redir_pc   = redirect_pc & ~XLEN'(INS_BYTES - 1);
    assign next_pc    = fetch_pc + STEP;
    assign push       = state == WAIT && imem_ack && !redirect;
    assign pop        = id_valid && id_ready && !redirect;
    assign post_count = count + CW'(push) - CW'(pop);
    assign din        = '{ins: imem_rdata, pc: fetch_pc};
    assign imem_req   = state != IDLE;

    // Head fields read as zero while the buffer is empty, so decode never sees stale data.
    assign id_valid = count != '0;
    assign id_ins   = id_valid ? head.ins : '0;
    assign id_pc    = id_valid ? head.pc : '0;
    assign id_pcp4  = id_valid ? head.pc + STEP : '0;

    y_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(redirect),
        .din  (din),
        .head (head),
        .count(count)
    );

    // imem_addr is latched at issue so a redirect during DISCARD cannot disturb the held request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= redir_pc;
                    end else if (count < CW'(DEPTH)) begin
                        state     <= WAIT;
                        imem_addr <= fetch_pc;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        fetch_pc <= redir_pc;
                        state    <= imem_ack ? IDLE : DISCARD;
                    end else if (imem_ack) begin
                        fetch_pc <= next_pc;
                        if (post_count < CW'(DEPTH)) imem_addr <= next_pc;
                        else state <= IDLE;
                    end
                end
                DISCARD: begin
                    if (redirect) fetch_pc <= redir_pc;
                    if (imem_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall   <= '0;
            perf_discard <= '0;
        end else begin
            if (!id_valid && state != DISCARD && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
            if (imem_ack && (state == DISCARD || (state == WAIT && redirect)) && perf_discard != '1)
                perf_discard <= perf_discard + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_y_fetch_queue.sv
// tb_y_fetch_queue: randomized self-checking bench against a transaction-level fetch model.
module tb_y_fetch_queue;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, redirect, imem_ack, id_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, id_valid;
    logic [31:0] imem_addr, id_ins, id_pc, id_pcp4;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_stall, perf_discard;
`endif

    always #5 clk = ~clk;

    y_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h80)) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ins     (id_ins),
        .id_pc      (id_pc),
        .id_pcp4    (id_pcp4),
        .id_ready   (id_ready)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_stall  (perf_stall),
        .perf_discard(perf_discard)
`endif
    );

    int          n_tests = 0, n_fail = 0;
    ent_t        q[$];
    logic [31:0] req_log[$], del_log[$];
    logic        pending, discard, rdy;
    logic [31:0] p_addr, exp_pc;
    int          wait_cnt, gap, lat, ack_cnt, m_stall, m_disc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic reset_dut(input logic late_ack);
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_ack = late_ack; imem_rdata = 32'hDEAD_BEEF; id_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", id_valid, 1'b0);
        check("rst_ins", id_ins, 32'h0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_pcp4", id_pcp4, 32'h0);
`ifdef IF_PERF_CNT_EN
        check("rst_perf_stall", perf_stall, 32'h0);
        check("rst_perf_discard", perf_discard, 32'h0);
`endif
        q.delete(); req_log.delete(); del_log.delete();
        pending = 1'b0; discard = 1'b0; exp_pc = 32'h80; gap = 0; ack_cnt = 0; m_stall = 0; m_disc = 0;
        rst = 1'b0; id_ready = 1'b1;
        m_stall++;
        @(negedge clk);
        imem_ack = 1'b0;
    endtask

    // One cycle: compare DUT outputs with the model, drive inputs, then advance the model.
    task automatic step(input logic rd, input logic [31:0] rpc);
        logic        do_ack;
        logic [31:0] data;
        check("id_valid", id_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("id_ins", id_ins, q[0].ins);
            check("id_pc", id_pc, q[0].pc);
            check("id_pcp4", id_pcp4, q[0].pc + 32'd4);
        end
`ifdef IF_PERF_CNT_EN
        check("perf_stall", perf_stall, m_stall);
        check("perf_discard", perf_discard, m_disc);
`endif
        if (pending) begin
            gap = 0;
            check("req_hold", imem_req, 1'b1);
            check("addr_hold", imem_addr, p_addr);
        end else if (imem_req) begin
            gap = 0;
            check("req_addr", imem_addr, exp_pc);
            check("no_overflow", q.size() < DEPTH, 1'b1);
            pending = 1'b1; p_addr = imem_addr; wait_cnt = 0;
            req_log.push_back(imem_addr);
        end else if (q.size() < DEPTH) begin
            gap++;
            check("issue_gap", gap <= 3, 1'b1);
        end else begin
            gap = 0;
        end
        do_ack = pending && wait_cnt >= lat;
        data = $urandom;
        imem_ack = do_ack; imem_rdata = data; id_ready = rdy; redirect = rd; redirect_pc = rpc;
        if (q.size() == 0 && !discard) m_stall++;
        if (q.size() != 0 && rdy && !rd) begin
            del_log.push_back(q[0].pc);
            void'(q.pop_front());
        end
        if (rd) q.delete();
        if (do_ack) begin
            pending = 1'b0;
            if (discard || rd) begin
                discard = 1'b0;
                m_disc++;
            end else begin
                q.push_back('{ins: data, pc: p_addr});
                exp_pc = p_addr + 32'd4;
                ack_cnt++;
            end
        end else if (pending) begin
            wait_cnt++;
        end
        if (rd) begin
            exp_pc = rpc & ~32'h3;
            discard = pending;
            gap = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ri, di, guard;
        @(negedge clk);

        // Sequential fetch, ack one cycle after each request.
        lat = 1; rdy = 1'b1;
        reset_dut(1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, '0);
        check("t1_nreq", req_log.size() >= 3, 1'b1);
        check("t1_req0", req_log[0], 32'h80);
        check("t1_req1", req_log[1], 32'h84);
        check("t1_req2", req_log[2], 32'h88);
        check("t1_del0", del_log[0], 32'h80);
        check("t1_del1", del_log[1], 32'h84);

        // Decode stalled with zero-latency memory: buffer fills then fetch stops.
        lat = 0; rdy = 1'b0;
        reset_dut(1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, '0);
        check("t2_acks", ack_cnt, 2);
        check("t2_req_off", imem_req, 1'b0);
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, '0);
        check("t2_req2", req_log[2], 32'h88);
        check("t2_del0", del_log[0], 32'h80);
        check("t2_del1", del_log[1], 32'h84);
        check("t2_del2", del_log[2], 32'h88);

        // Redirect while waiting on a slow ack: the late data must be dropped.
        lat = 3; rdy = 1'b1;
        reset_dut(1'b0);
        guard = 0;
        while (!(pending && p_addr == 32'h84) && guard < 50) begin
            step(1'b0, '0);
            guard++;
        end
        check("t3_reach", guard < 50, 1'b1);
        di = del_log.size();
        step(1'b1, 32'h200);
        ri = req_log.size();
        for (int i = 0; i < 20; i++) step(1'b0, '0);
        check("t3_nreq", req_log.size() > ri, 1'b1);
        check("t3_req", req_log[ri], 32'h200);
        check("t3_del", del_log[di], 32'h200);

        // Redirect coinciding with an ack and a pop.
        lat = 0; rdy = 1'b1;
        reset_dut(1'b0);
        guard = 0;
        while (del_log.size() < 2 && guard < 50) begin
            step(1'b0, '0);
            guard++;
        end
        check("t4_reach", guard < 50, 1'b1);
        di = del_log.size();
        step(1'b1, 32'h300);
        check("t4_flush", id_valid, 1'b0);
        ri = req_log.size();
        for (int i = 0; i < 10; i++) step(1'b0, '0);
        check("t4_req", req_log[ri], 32'h300);
        check("t4_del", del_log[di], 32'h300);

        // Address wrap and unaligned redirect target.
        step(1'b1, 32'hFFFF_FFFC);
        ri = req_log.size();
        for (int i = 0; i < 10; i++) step(1'b0, '0);
        check("t5_req_top", req_log[ri], 32'hFFFF_FFFC);
        check("t5_req_wrap", req_log[ri + 1], 32'h0);
        step(1'b1, 32'h203);
        ri = req_log.size();
        for (int i = 0; i < 8; i++) step(1'b0, '0);
        check("t5_align", req_log[ri], 32'h200);

        // Reset mid-transaction followed by a stray ack.
        lat = 3;
        guard = 0;
        while (!pending && guard < 20) begin
            step(1'b0, '0);
            guard++;
        end
        reset_dut(1'b1);
        lat = 1;
        for (int i = 0; i < 8; i++) step(1'b0, '0);
        check("t6_req0", req_log[0], 32'h80);
        check("t6_del0", del_log[0], 32'h80);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(0, 3);
            rdy = $urandom_range(0, 3) != 0;
            step($urandom_range(0, 31) == 0, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
